// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Contents: parity mode encodings, transmit FSM state encoding and a parity-enable helper.
package uart_pkg;

  // Parity mode encodings as presented on ParityMode; 2'b11 also means no parity
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // True when the mode inserts a parity bit
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-facing bus of the buffered UART transmitter.
// master: producer side (drives config, Data, Valid; observes Ready, Level, Busy, Tx).
// slave : transmitter side (the uart_tx_fifo block).
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 4
);

  logic [DIV_W-1:0]  Divisor;
  logic [1:0]        ParityMode;
  logic              TwoStop;
  logic [DATA_W-1:0] Data;
  logic              Valid;
  logic              Ready;
  logic [FIFO_AW:0]  Level;
  logic              Busy;
  logic              Tx;

  modport master (
    output Divisor, ParityMode, TwoStop, Data, Valid,
    input  Ready, Level, Busy, Tx
  );

  modport slave (
    input  Divisor, ParityMode, TwoStop, Data, Valid,
    output Ready, Level, Busy, Tx
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
// Ports: clk, rst_n (synchronous, active-low), push/wr_data, pop/rd_data,
//        full, empty, count (registered occupancy, 0..2**AW).
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Flags decode straight from the registered occupancy
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in a FIFO and leave on Tx as back-to-back frames.
// Ports: Clk, nReset (synchronous, active-low), bus (uart_tx_fifo_if.slave):
//   Divisor/ParityMode/TwoStop are captured at each frame start, Data/Valid/Ready
//   form the write handshake, Level is FIFO occupancy, Busy flags an active or
//   chained frame, Tx is the registered serial line (idle high).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic            Clk,
  input  logic            nReset,
  uart_tx_fifo_if.slave   bus
);

  localparam int unsigned CNT_W = 4;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [1:0]        par_sh_q, par_sh_d;
  logic              two_sh_q, two_sh_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              pop;
  logic              load;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [FIFO_AW:0]  count;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (nReset),
    .push    (bus.Valid),
    .wr_data (bus.Data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bus.Ready = ~full;
  assign bus.Level = count;
  assign bus.Busy  = busy_q;
  assign bus.Tx    = tx_q;

  // Next-state, bit timing and frame sequencing
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_sh_d  = div_sh_q;
    par_sh_d  = par_sh_q;
    two_sh_d  = two_sh_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    load      = 1'b0;

    if (state_q == ST_IDLE) begin
      load = !empty;
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - DIV_W'(1);
    end else begin
      // Bit boundary: reload the divider and advance the frame
      div_cnt_d = div_sh_q;
      case (state_q)
        ST_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            if (parity_en(par_sh_q)) begin
              tx_d    = par_bit_q;
              state_d = ST_PARITY;
            end else begin
              tx_d      = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          if (two_sh_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else if (!empty) begin
            // Chain straight into the next start bit
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end

    // Frame start: pop the head word and snapshot the run-time configuration
    if (load) begin
      pop       = 1'b1;
      shift_d   = head;
      div_sh_d  = bus.Divisor;
      div_cnt_d = bus.Divisor;
      par_sh_d  = bus.ParityMode;
      two_sh_d  = bus.TwoStop;
      par_bit_d = (bus.ParityMode == PAR_ODD) ? ~^head : ^head;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      state_d   = ST_START;
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      div_sh_q  <= '0;
      par_sh_q  <= PAR_NONE;
      two_sh_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_sh_q  <= div_sh_d;
      par_sh_q  <= par_sh_d;
      two_sh_q  <= two_sh_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned FIFO_AW = 4;

  logic clk = 1'b0;
  logic n_reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) bus ();

  uart_tx_fifo #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .Clk    (clk),
    .nReset (n_reset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle write pulse; called and returns on a falling edge
  task automatic push(input logic [7:0] d);
    bus.Data  = d;
    bus.Valid = 1'b1;
    @(negedge clk);
    bus.Valid = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.Tx == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples a frame starting at the first start-bit cycle; bad counts mid-bit changes
  task automatic rx_frame(input int nbt, input int cpb, output logic [15:0] bits,
                          output int bad, output logic busy_last);
    bits      = '0;
    bad       = 0;
    busy_last = 1'b0;
    for (int b = 0; b < nbt; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (c == 0) bits[b] = bus.Tx;
        else if (bus.Tx !== bits[b]) bad++;
        if ((b == nbt - 1) && (c == cpb - 1)) busy_last = bus.Busy;
        @(negedge clk);
      end
    end
  endtask

  task automatic one_frame(input string tag, input logic [1:0] pm, input logic ts,
                           input logic [15:0] div, input logic [7:0] d, input int nbt,
                           input logic [15:0] exp_bits);
    logic [15:0] bits;
    int          bad;
    logic        bl;
    bus.ParityMode = pm;
    bus.TwoStop    = ts;
    bus.Divisor    = div;
    push(d);
    chk({tag, " tx before start"}, 32'(bus.Tx), 32'd1);
    chk({tag, " level after push"}, 32'(bus.Level), 32'd1);
    @(negedge clk);
    chk({tag, " tx start latency"}, 32'(bus.Tx), 32'd0);
    chk({tag, " busy at start"}, 32'(bus.Busy), 32'd1);
    rx_frame(nbt, int'(div) + 1, bits, bad, bl);
    chk({tag, " bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, " bit width"}, 32'(bad), 32'd0);
    chk({tag, " busy last stop"}, 32'(bl), 32'd1);
    chk({tag, " busy after"}, 32'(bus.Busy), 32'd0);
    chk({tag, " tx idle after"}, 32'(bus.Tx), 32'd1);
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] bits2;
    int          bad;
    int          bad2;
    logic        bl;
    bit          found;
    int          acc;
    int          tx_low;
    int          busy_hi;
    logic [7:0]  ed;

    // Reset with Valid held high
    n_reset        = 1'b0;
    bus.Valid      = 1'b1;
    bus.Data       = 8'h5A;
    bus.Divisor    = 16'd3;
    bus.ParityMode = 2'b00;
    bus.TwoStop    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst tx", 32'(bus.Tx), 32'd1);
    chk("rst busy", 32'(bus.Busy), 32'd0);
    chk("rst level", 32'(bus.Level), 32'd0);
    chk("rst ready", 32'(bus.Ready), 32'd1);
    bus.Valid = 1'b0;
    n_reset   = 1'b1;
    @(negedge clk);
    chk("rst no push", 32'(bus.Level), 32'd0);
    chk("rst idle tx", 32'(bus.Tx), 32'd1);

    // Single frames: start, data LSB first, optional parity, stop(s)
    one_frame("basic a5", 2'b00, 1'b0, 16'd3, 8'hA5, 10, 16'h034A);
    one_frame("even 07", 2'b01, 1'b0, 16'd3, 8'h07, 11, 16'h060E);
    one_frame("odd 07", 2'b10, 1'b0, 16'd3, 8'h07, 11, 16'h040E);
    one_frame("two stop", 2'b01, 1'b1, 16'd3, 8'h07, 12, 16'h0E0E);
    one_frame("div0 c3", 2'b11, 1'b0, 16'd0, 8'hC3, 10, 16'h0386);

    // Fill with Valid held high while the first frame is on the line
    bus.Divisor    = 16'd100;
    bus.ParityMode = 2'b00;
    bus.TwoStop    = 1'b0;
    fork
      begin
        acc = 0;
        while (bus.Ready && (acc < 40)) begin
          bus.Data  = 8'h10 + 8'(acc);
          bus.Valid = 1'b1;
          @(negedge clk);
          acc++;
        end
        chk("fill accepted", 32'(acc), 32'd17);
        chk("fill level", 32'(bus.Level), 32'd16);
        bus.Data = 8'hFF;
        repeat (5) @(negedge clk);
        chk("full ignore level", 32'(bus.Level), 32'd16);
        chk("full ready", 32'(bus.Ready), 32'd0);
        bus.Valid = 1'b0;
      end
      begin
        wait_start(found);
        chk("fill start seen", 32'(found), 32'd1);
        for (int f = 0; f < 17; f++) begin
          rx_frame(10, 101, bits, bad, bl);
          ed = 8'h10 + 8'(f);
          chk("fill frame bits", 32'(bits), 32'({6'b0, 1'b1, ed, 1'b0}));
          chk("fill frame width", 32'(bad), 32'd0);
          if (f < 16) chk("fill no gap", 32'(bus.Tx), 32'd0);
        end
        chk("fill busy end", 32'(bus.Busy), 32'd0);
        chk("fill level end", 32'(bus.Level), 32'd0);
      end
    join

    // Divisor change mid-frame only affects the following frame
    bus.Divisor = 16'd3;
    push(8'h55);
    push(8'h0F);
    wait_start(found);
    chk("reconf start seen", 32'(found), 32'd1);
    fork
      rx_frame(10, 4, bits, bad, bl);
      begin
        repeat (10) @(negedge clk);
        bus.Divisor = 16'd7;
      end
    join
    chk("reconf f1 bits", 32'(bits), 32'h2AA);
    chk("reconf f1 width", 32'(bad), 32'd0);
    chk("reconf no gap", 32'(bus.Tx), 32'd0);
    rx_frame(10, 8, bits2, bad2, bl);
    chk("reconf f2 bits", 32'(bits2), 32'h21E);
    chk("reconf f2 width", 32'(bad2), 32'd0);
    chk("reconf busy end", 32'(bus.Busy), 32'd0);

    // Reset during data bit 3 with five words queued
    bus.Divisor = 16'd3;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    chk("midrst level", 32'(bus.Level), 32'd5);
    repeat (13) @(negedge clk);
    chk("midrst pre tx", 32'(bus.Tx), 32'd0);
    n_reset = 1'b0;
    @(negedge clk);
    chk("midrst tx", 32'(bus.Tx), 32'd1);
    chk("midrst level", 32'(bus.Level), 32'd0);
    chk("midrst busy", 32'(bus.Busy), 32'd0);
    chk("midrst ready", 32'(bus.Ready), 32'd1);
    n_reset = 1'b1;
    tx_low  = 0;
    busy_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.Tx !== 1'b1) tx_low++;
      if (bus.Busy !== 1'b0) busy_hi++;
    end
    chk("midrst quiet tx", 32'(tx_low), 32'd0);
    chk("midrst quiet busy", 32'(busy_hi), 32'd0);
    chk("midrst quiet level", 32'(bus.Level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
